// File: rtl/fifo_thresh_ctrl_pkg.sv
// Shared constants for the threshold FIFO: default geometry and output-mode codes.
package fifo_thresh_ctrl_pkg;

  // Default geometry: 8 words of 10 bits, 3-bit pointers.
  localparam int DEF_WORD_SIZE = 10;
  localparam int DEF_MEM_SIZE  = 8;
  localparam int DEF_PTR       = 3;

  // Output mode codes for the FWFT parameter.
  localparam int FWFT_REGISTERED  = 0;  // word appears the cycle after pop
  localparam int FWFT_FALLTHROUGH = 1;  // head word is always presented

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
// No reset: contents survive a FIFO reset and are simply overwritten later.
module fifo_mem
  import fifo_thresh_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int PTR       = DEF_PTR
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR-1:0]       wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [PTR-1:0]       rd_addr,
  output logic [WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  // Store the incoming word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_thresh_ctrl.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and a selectable output mode.
//
// Handshake: fifo_wr/fifo_rd are requests that may be held any number of cycles;
// push/pop report, combinationally in the same cycle, whether the request is
// accepted on the coming rising edge. A read is accepted only when not empty; a
// write is accepted when not full, or when full and a read is accepted in the
// same cycle. A rejected request raises the matching sticky error flag.
module fifo_thresh_ctrl
  import fifo_thresh_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int MEM_SIZE  = DEF_MEM_SIZE,
  parameter int PTR       = DEF_PTR,
  parameter int FWFT      = FWFT_REGISTERED
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic                 fifo_rd,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic [PTR:0]         full_threshold,
  input  logic [PTR:0]         empty_threshold,
  input  logic                 err_clr,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 data_valid,
  output logic                 push,
  output logic                 pop,
  output logic [PTR:0]         fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam logic [PTR:0]   FULL_COUNT = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0]   COUNT_ONE  = (PTR+1)'(1);
  localparam logic [PTR-1:0] PTR_ONE    = PTR'(1);

  logic [PTR-1:0]       wr_ptr;
  logic [PTR-1:0]       rd_ptr;
  logic [PTR:0]         count_next;
  logic [WORD_SIZE-1:0] mem_rd_data;

  // Acceptance. On empty a read is never accepted, so an rd+wr pair on empty
  // stores the word and flags underflow; there is no write-through path.
  assign pop  = fifo_rd & ~fifo_empty;
  assign push = fifo_wr & (~fifo_full | pop);

  // Next occupancy: +1 on push only, -1 on pop only, unchanged on both or neither.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + COUNT_ONE;
    end else if (pop && !push) begin
      count_next = fifo_count - COUNT_ONE;
    end
  end

  fifo_mem #(
    .WORD_SIZE (WORD_SIZE),
    .MEM_SIZE  (MEM_SIZE),
    .PTR       (PTR)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (fifo_data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd_data)
  );

  // Pointers advance on acceptance; PTR-bit arithmetic wraps at MEM_SIZE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Count and status flags, all registered from the next count so they agree.
  // Thresholds are sampled every cycle, so a new value shows one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      fifo_count   <= count_next;
      fifo_full    <= (count_next == FULL_COUNT);
      fifo_empty   <= (count_next == '0);
      almost_full  <= (count_next >= full_threshold);
      almost_empty <= (count_next <= empty_threshold);
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (fifo_wr & ~push) | (overflow_err  & ~err_clr);
      underflow_err <= (fifo_rd & ~pop)  | (underflow_err & ~err_clr);
    end
  end

  generate
    if (FWFT == FWFT_FALLTHROUGH) begin : g_fwft
      // Head word is presented directly. The output is forced to zero while empty
      // so it never shows stale or uninitialised storage (and reads 0 after reset).
      assign fifo_data_out = fifo_empty ? '0 : mem_rd_data;
      assign data_valid    = ~fifo_empty;
    end else begin : g_registered
      logic [WORD_SIZE-1:0] data_q;
      logic                 valid_q;

      // Capture the head word on pop; valid is a one-cycle pulse after each pop.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop;
          if (pop) data_q <= mem_rd_data;
        end
      end

      assign fifo_data_out = data_q;
      assign data_valid    = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_thresh_ctrl.sv
// Directed bench for fifo_thresh_ctrl. Two instances share all inputs: r_* is the
// registered-output build (FWFT=0), f_* the fall-through build (FWFT=1).
module tb_fifo_thresh_ctrl;

  localparam int W = 10;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         fifo_wr, fifo_rd, err_clr;
  logic [W-1:0] fifo_data_in;
  logic [P:0]   full_threshold, empty_threshold;

  logic [W-1:0] r_dout, f_dout;
  logic         r_valid, f_valid, r_push, f_push, r_pop, f_pop;
  logic [P:0]   r_count, f_count;
  logic         r_full, f_full, r_empty, f_empty, r_af, f_af, r_ae, f_ae;
  logic         r_ovf, f_ovf, r_unf, f_unf;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_word;

  // Clock / reset block
  always #5 clk = ~clk;

  fifo_thresh_ctrl #(.WORD_SIZE(W), .MEM_SIZE(8), .PTR(P), .FWFT(0)) dut_r (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_data_in(fifo_data_in), .full_threshold(full_threshold),
    .empty_threshold(empty_threshold), .err_clr(err_clr),
    .fifo_data_out(r_dout), .data_valid(r_valid), .push(r_push), .pop(r_pop),
    .fifo_count(r_count), .fifo_full(r_full), .fifo_empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae),
    .overflow_err(r_ovf), .underflow_err(r_unf)
  );

  fifo_thresh_ctrl #(.WORD_SIZE(W), .MEM_SIZE(8), .PTR(P), .FWFT(1)) dut_f (
    .clk(clk), .reset(reset), .fifo_wr(fifo_wr), .fifo_rd(fifo_rd),
    .fifo_data_in(fifo_data_in), .full_threshold(full_threshold),
    .empty_threshold(empty_threshold), .err_clr(err_clr),
    .fifo_data_out(f_dout), .data_valid(f_valid), .push(f_push), .pop(f_pop),
    .fifo_count(f_count), .fifo_full(f_full), .fifo_empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae),
    .overflow_err(f_ovf), .underflow_err(f_unf)
  );

  // Driver tasks: advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fifo_wr = 1'b0; fifo_rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    fifo_data_in = '0; full_threshold = 4'd6; empty_threshold = 4'd2;
    reset = 1'b0;
    #12;
    n_checks++; if (r_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", r_count); end
    n_checks++; if ({r_empty, r_ae, r_full, r_af} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags: got %b want 1100", {r_empty, r_ae, r_full, r_af}); end
    n_checks++; if ({r_ovf, r_unf, f_ovf, f_unf} !== 4'b0000) begin n_fail++; $display("FAIL reset_errs: got %b want 0000", {r_ovf, r_unf, f_ovf, f_unf}); end
    n_checks++; if ({r_valid, f_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {r_valid, f_valid}); end
    n_checks++; if (r_dout !== 10'h000 || f_dout !== 10'h000) begin n_fail++; $display("FAIL reset_dout: got %h/%h want 000/000", r_dout, f_dout); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      fifo_wr = 1'b1; fifo_data_in = W'(i);
      #1;
      n_checks++; if (r_push !== 1'b1) begin n_fail++; $display("FAIL fill_push[%0d]: got %b want 1", i, r_push); end
      tick();
      n_checks++; if (r_count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, r_count, i); end
      n_checks++; if (r_full !== (i == 8)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, r_full, (i == 8)); end
      n_checks++; if (r_af !== (i >= 6)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, r_af, (i >= 6)); end
      n_checks++; if (r_ae !== (i <= 2) || r_empty !== 1'b0) begin n_fail++; $display("FAIL fill_ae_empty[%0d]: got %b%b want %b0", i, r_ae, r_empty, (i <= 2)); end
      n_checks++; if (f_valid !== 1'b1 || f_dout !== 10'h001) begin n_fail++; $display("FAIL fill_fwft_head[%0d]: got %b/%h want 1/001", i, f_valid, f_dout); end
      n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL fill_r_valid[%0d]: got %b want 0", i, r_valid); end
    end
    // Ninth write into a full FIFO is rejected.
    fifo_data_in = 10'h009;
    #1;
    n_checks++; if (r_push !== 1'b0) begin n_fail++; $display("FAIL overflow_push: got %b want 0", r_push); end
    tick();
    n_checks++; if (r_ovf !== 1'b1 || f_ovf !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b/%b want 1/1", r_ovf, f_ovf); end
    n_checks++; if (r_count !== 4'd8) begin n_fail++; $display("FAIL overflow_count: got %0d want 8", r_count); end
    idle();
  endtask

  task automatic test_err_clr();
    // Another rejected write coincident with err_clr: the set wins.
    fifo_wr = 1'b1; err_clr = 1'b1;
    tick();
    n_checks++; if (r_ovf !== 1'b1) begin n_fail++; $display("FAIL errclr_priority: got %b want 1", r_ovf); end
    fifo_wr = 1'b0;
    tick();
    n_checks++; if (r_ovf !== 1'b0) begin n_fail++; $display("FAIL errclr_clear: got %b want 0", r_ovf); end
    err_clr = 1'b0;
    tick();
    n_checks++; if (r_ovf !== 1'b0 || r_count !== 4'd8) begin n_fail++; $display("FAIL errclr_hold: got %b/%0d want 0/8", r_ovf, r_count); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      fifo_rd = 1'b1;
      #1;
      n_checks++; if (r_pop !== 1'b1) begin n_fail++; $display("FAIL drain_pop[%0d]: got %b want 1", i, r_pop); end
      tick();
      n_checks++; if (r_valid !== 1'b1 || r_dout !== W'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %b/%h want 1/%h", i, r_valid, r_dout, W'(i)); end
      n_checks++; if (r_count !== 4'(8 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, r_count, 8 - i); end
      n_checks++; if (f_valid !== (i < 8)) begin n_fail++; $display("FAIL drain_fwft_valid[%0d]: got %b want %b", i, f_valid, (i < 8)); end
    end
    fifo_rd = 1'b0;
    tick();
    n_checks++; if (r_valid !== 1'b0 || r_dout !== 10'h008) begin n_fail++; $display("FAIL drain_hold: got %b/%h want 0/008", r_valid, r_dout); end
    n_checks++; if (r_empty !== 1'b1 || r_ae !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b%b want 11", r_empty, r_ae); end
    fifo_rd = 1'b1;
    #1;
    n_checks++; if (r_pop !== 1'b0) begin n_fail++; $display("FAIL underflow_pop: got %b want 0", r_pop); end
    tick();
    n_checks++; if (r_unf !== 1'b1 || r_count !== 4'd0) begin n_fail++; $display("FAIL underflow_err: got %b/%0d want 1/0", r_unf, r_count); end
    fifo_rd = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (r_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b want 0", r_unf); end
  endtask

  task automatic test_full_rdwr();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      fifo_wr = 1'b1; fifo_data_in = W'(10'h010 + i);
      exp_q.push_back(W'(10'h010 + i));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      fifo_wr = 1'b1; fifo_rd = 1'b1; fifo_data_in = W'(10'h020 + k);
      #1;
      n_checks++; if ({r_push, r_pop} !== 2'b11) begin n_fail++; $display("FAIL full_rdwr_accept[%0d]: got %b want 11", k, {r_push, r_pop}); end
      exp_word = exp_q.pop_front();
      exp_q.push_back(W'(10'h020 + k));
      tick();
      n_checks++; if (r_count !== 4'd8 || r_full !== 1'b1 || r_ovf !== 1'b0) begin n_fail++; $display("FAIL full_rdwr_status[%0d]: got %0d/%b/%b want 8/1/0", k, r_count, r_full, r_ovf); end
      n_checks++; if (r_dout !== exp_word) begin n_fail++; $display("FAIL full_rdwr_data[%0d]: got %h want %h", k, r_dout, exp_word); end
    end
    fifo_wr = 1'b0;
    // Drain across the pointer wrap and compare against the expected queue.
    for (int i = 0; i < 8; i++) begin
      fifo_rd = 1'b1;
      exp_word = exp_q.pop_front();
      tick();
      n_checks++; if (r_dout !== exp_word) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, r_dout, exp_word); end
    end
    fifo_rd = 1'b0;
    tick();
    n_checks++; if (r_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", r_empty); end
  endtask

  task automatic test_empty_rdwr();
    fifo_wr = 1'b1; fifo_rd = 1'b1; fifo_data_in = 10'h155;
    #1;
    n_checks++; if ({r_push, r_pop} !== 2'b10) begin n_fail++; $display("FAIL empty_rdwr_accept: got %b want 10", {r_push, r_pop}); end
    tick();
    n_checks++; if (r_unf !== 1'b1 || r_count !== 4'd1) begin n_fail++; $display("FAIL empty_rdwr_state: got %b/%0d want 1/1", r_unf, r_count); end
    n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL empty_rdwr_nothrough: got %b want 0", r_valid); end
    n_checks++; if (f_dout !== 10'h155) begin n_fail++; $display("FAIL empty_rdwr_fwft: got %h want 155", f_dout); end
    fifo_wr = 1'b0; fifo_rd = 1'b1;
    tick();
    n_checks++; if (r_valid !== 1'b1 || r_dout !== 10'h155) begin n_fail++; $display("FAIL empty_rdwr_read: got %b/%h want 1/155", r_valid, r_dout); end
    fifo_rd = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_threshold();
    fifo_wr = 1'b1; fifo_data_in = 10'h00A;
    tick();
    fifo_data_in = 10'h00B;
    tick();
    fifo_wr = 1'b0;
    n_checks++; if ({r_af, r_ae} !== 2'b01) begin n_fail++; $display("FAIL thresh_base: got %b want 01", {r_af, r_ae}); end
    full_threshold = 4'd2; empty_threshold = 4'd1;
    tick();
    n_checks++; if ({r_af, r_ae} !== 2'b10) begin n_fail++; $display("FAIL thresh_change: got %b want 10", {r_af, r_ae}); end
    full_threshold = 4'd6; empty_threshold = 4'd2;
    tick();
    n_checks++; if ({r_af, r_ae} !== 2'b01) begin n_fail++; $display("FAIL thresh_restore: got %b want 01", {r_af, r_ae}); end
  endtask

  task automatic test_fwft();
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    tick();
    fifo_wr = 1'b1; fifo_data_in = 10'h2AA;
    tick();
    fifo_wr = 1'b0;
    n_checks++; if (f_valid !== 1'b1 || f_dout !== 10'h2AA) begin n_fail++; $display("FAIL fwft_head: got %b/%h want 1/2aa", f_valid, f_dout); end
    tick();
    n_checks++; if (f_valid !== 1'b1 || r_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_hold: got %b/%b want 1/0", f_valid, r_valid); end
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_after_pop: got %b want 0", f_valid); end
    n_checks++; if (r_dout !== 10'h2AA || r_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_r_read: got %b/%h want 1/2aa", r_valid, r_dout); end
    tick();
  endtask

  task automatic test_reset_mid();
    fifo_rd = 1'b1;
    tick();
    fifo_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fifo_wr = 1'b1; fifo_data_in = W'(10'h031 + i);
      tick();
    end
    fifo_wr = 1'b0;
    n_checks++; if (r_count !== 4'd5 || r_unf !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got %0d/%b want 5/1", r_count, r_unf); end
    reset = 1'b0;
    #1;
    n_checks++; if (r_count !== 4'd0 || r_empty !== 1'b1 || r_ae !== 1'b1) begin n_fail++; $display("FAIL midrst_status: got %0d/%b/%b want 0/1/1", r_count, r_empty, r_ae); end
    n_checks++; if ({r_unf, r_ovf, r_valid, f_valid} !== 4'b0000 || r_dout !== 10'h000) begin n_fail++; $display("FAIL midrst_clear: got %b/%h want 0000/000", {r_unf, r_ovf, r_valid, f_valid}, r_dout); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    fifo_wr = 1'b1; fifo_data_in = 10'h0AB;
    tick();
    fifo_wr = 1'b0; fifo_rd = 1'b1;
    n_checks++; if (r_count !== 4'd1 || f_dout !== 10'h0AB) begin n_fail++; $display("FAIL midrst_write: got %0d/%h want 1/0ab", r_count, f_dout); end
    tick();
    fifo_rd = 1'b0;
    n_checks++; if (r_dout !== 10'h0AB || r_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_read: got %b/%h want 1/0ab", r_valid, r_dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_err_clr();
    test_drain();
    test_full_rdwr();
    test_empty_rdwr();
    test_threshold();
    test_fwft();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
